// File: rtl/spi_cmd_if.sv
//------------------------------------------------------------------------------
// Module      : spi_cmd_if
// Description : Byte-stream input and register/trigger output bundle of the
//               SPI command sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_cmd_if #(
    parameter int DATA_BYTES = 2
);
    logic                    i_cs;
    logic                    i_spi_done;
    logic [7:0]              i_rx_byte;
    logic                    o_wr_en;
    logic [5:0]              o_wr_addr;
    logic [8*DATA_BYTES-1:0] o_wr_data;
    logic                    o_trig;
    logic                    o_err;
    logic [7:0]              o_err_cnt;
    logic                    o_busy;

    modport slave (
        input  i_cs, i_spi_done, i_rx_byte,
        output o_wr_en, o_wr_addr, o_wr_data, o_trig, o_err, o_err_cnt, o_busy
    );

    modport master (
        output i_cs, i_spi_done, i_rx_byte,
        input  o_wr_en, o_wr_addr, o_wr_data, o_trig, o_err, o_err_cnt, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
//------------------------------------------------------------------------------
// Module      : spi_cmd_ctrl
// Description : Parses CS-framed SPI byte streams into register writes,
//               trigger strobes and counted protocol errors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_cmd_ctrl #(
    parameter int DATA_BYTES = 2,
    parameter int MAX_ADDR   = 63
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst_n,
    spi_cmd_if.slave    bus
);
    localparam int         WORD_W     = 8 * DATA_BYTES;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_TRIG   = 2'b10;
    localparam logic [1:0] CMD_RSVD   = 2'b11;
    localparam logic [1:0] LAST_BYTE  = 2'(DATA_BYTES - 1);
    localparam logic [6:0] MAX_A7     = 7'(MAX_ADDR);
    localparam logic [5:0] MAX_A      = 6'(MAX_ADDR);

    logic [1:0]        cs_sync_q;
    logic [1:0]        state_q, state_d;
    logic [5:0]        addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              wr_en_q, wr_en_d;
    logic [5:0]        wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              trig_q, trig_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              busy_q, busy_d;

    logic              w_cs_active;
    logic [1:0]        w_cmd;
    logic              w_addr_ok;
    logic              w_word_done;
    logic [WORD_W-1:0] w_acc_shift;

    assign w_cs_active = ~cs_sync_q[1];
    assign w_cmd       = bus.i_rx_byte[7:6];
    assign w_addr_ok   = ({1'b0, bus.i_rx_byte[5:0]} <= MAX_A7);
    assign w_word_done = (cnt_q == LAST_BYTE);
    assign w_acc_shift = (acc_q << 8) | WORD_W'(bus.i_rx_byte);

    // Sync flops idle high so a CS held low across reset is seen as a fresh frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_sync_q <= 2'b11;
            state_q   <= ST_IDLE;
        end else begin
            cs_sync_q <= {cs_sync_q[0], bus.i_cs};
            state_q   <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_cs_active) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (bus.i_spi_done) begin
                    if (w_cmd == CMD_WRITE && w_addr_ok) state_d = ST_DATA;
                    else                                 state_d = ST_DISCARD;
                end
            end
            ST_DATA: begin
                if (bus.i_spi_done && w_word_done && addr_q == MAX_A) state_d = ST_DISCARD;
            end
            default: state_d = state_q;
        endcase
        // The byte in flight is handled above before CS release takes effect.
        if (!w_cs_active) state_d = ST_IDLE;
    end

    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        trig_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (bus.i_spi_done) begin
                    case (w_cmd)
                        CMD_WRITE: begin
                            if (w_addr_ok) begin
                                addr_d = bus.i_rx_byte[5:0];
                                cnt_d  = 2'd0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_TRIG: trig_d = 1'b1;
                        CMD_RSVD: err_d  = 1'b1;
                        default:  ;
                    endcase
                end
            end
            ST_DATA: begin
                if (bus.i_spi_done) begin
                    acc_d = w_acc_shift;
                    if (w_word_done) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = w_acc_shift;
                        cnt_d     = 2'd0;
                        addr_d    = addr_q + 6'd1;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                if (!w_cs_active && cnt_d != 2'd0) err_d = 1'b1;
            end
            default: ;
        endcase
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            trig_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            trig_q    <= trig_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_wr_addr = wr_addr_q;
    assign bus.o_wr_data = wr_data_q;
    assign bus.o_trig    = trig_q;
    assign bus.o_err     = err_q;
    assign bus.o_err_cnt = err_cnt_q;
    assign bus.o_busy    = busy_q;
endmodule

`default_nettype wire
